priority_arbiter: RTL and testbench

- Parametrised, registered successor to the 8-input combinational priority encoder.
- Arbitrates N request lines and issues one grant at a time: index plus one-hot.
- Grant is delivered over a valid/ready handshake to a downstream consumer.
- Two modes: fixed priority, or round-robin with per-grant rotation. Used wherever several sources share one resource (bus, FIFO write port, shared ALU).

---
 rtl/priority_arbiter.sv | 119 +++++++++++
 tb/tb_priority_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter.sv
// Registered N-input arbiter: fixed priority or round-robin, one grant at a time.
// The grant is latched and held on a valid/ready handshake until the consumer accepts it.
module priority_arbiter #(
  parameter int  N           = 8,
  parameter int  ROUND_ROBIN = 1,
  parameter int  HIGH_FIRST  = 1,
  localparam int IDX_W       = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic [IDX_W-1:0] gnt_code,
  output logic [N-1:0]     gnt_onehot
);

  localparam int SCAN_W = IDX_W + 1;
  // Reset pointer makes the first round-robin scan identical to fixed priority.
  localparam logic [IDX_W-1:0] PTR_RST = (HIGH_FIRST != 0) ? '0 : IDX_W'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_code_q, gnt_code_d;
  logic [N-1:0]       gnt_onehot_q, gnt_onehot_d;
  logic               gnt_valid_q, gnt_valid_d;

  logic [IDX_W-1:0]   base;
  logic [SCAN_W-1:0]  scan;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [N-1:0]       sel_onehot;

  // On a transfer the just-served code is the new pointer, so search from it directly.
  always_comb begin
    base = PTR_RST;
    if (ROUND_ROBIN != 0) begin
      base = (state_q == GRANT) ? gnt_code_q : ptr_q;
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = '0;
    for (int k = 1; k <= N; k++) begin
      if (HIGH_FIRST != 0) begin
        scan = {1'b0, base} + SCAN_W'(N) - SCAN_W'(k);
      end else begin
        scan = {1'b0, base} + SCAN_W'(k);
      end
      if (scan >= SCAN_W'(N)) begin
        scan = scan - SCAN_W'(N);
      end
      if (!sel_found && req[scan[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan[IDX_W-1:0];
      end
    end
    sel_onehot = N'(1) << sel_idx;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_code_d   = gnt_code_q;
    gnt_onehot_d = gnt_onehot_q;
    gnt_valid_d  = gnt_valid_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_code_d   = sel_idx;
          gnt_onehot_d = sel_onehot;
          gnt_valid_d  = 1'b1;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          if (ROUND_ROBIN != 0) begin
            ptr_d = gnt_code_q;
          end
          if (|req) begin
            gnt_code_d   = sel_idx;
            gnt_onehot_d = sel_onehot;
          end else begin
            gnt_valid_d  = 1'b0;
            gnt_onehot_d = '0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_RST;
      gnt_code_q   <= '0;
      gnt_onehot_q <= '0;
      gnt_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_code_q   <= gnt_code_d;
      gnt_onehot_q <= gnt_onehot_d;
      gnt_valid_q  <= gnt_valid_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_code   = gnt_code_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench: three arbiter configurations share stimulus; expected codes are
// queued by the stimulus and popped by a monitor on every accepted grant.
module tb_priority_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       gnt_ready;

  logic       v_fh, v_fl, v_rr;
  logic [2:0] c_fh, c_fl, c_rr;
  logic [7:0] o_fh, o_fl, o_rr;

  typedef struct packed {
    logic [2:0] fh;
    logic [2:0] fl;
    logic [2:0] rr;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  priority_arbiter #(.N(8), .ROUND_ROBIN(0), .HIGH_FIRST(1)) u_fh (
    .clk(clk), .rst(rst), .req(req), .gnt_valid(v_fh), .gnt_ready(gnt_ready),
    .gnt_code(c_fh), .gnt_onehot(o_fh));
  priority_arbiter #(.N(8), .ROUND_ROBIN(0), .HIGH_FIRST(0)) u_fl (
    .clk(clk), .rst(rst), .req(req), .gnt_valid(v_fl), .gnt_ready(gnt_ready),
    .gnt_code(c_fl), .gnt_onehot(o_fl));
  priority_arbiter #(.N(8), .ROUND_ROBIN(1), .HIGH_FIRST(1)) u_rr (
    .clk(clk), .rst(rst), .req(req), .gnt_valid(v_rr), .gnt_ready(gnt_ready),
    .gnt_code(c_rr), .gnt_onehot(o_rr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] fh, input logic [2:0] fl, input logic [2:0] rr);
    exp_t e;
    e.fh = fh;
    e.fl = fl;
    e.rr = rr;
    sb_q.push_back(e);
  endtask

  // Monitor: one-hot consistency every cycle, scoreboard pop on each transfer.
  always @(negedge clk) begin
    exp_t e;
    chk("onehot_fh", o_fh, v_fh ? (8'b1 << c_fh) : 8'h00);
    chk("onehot_fl", o_fl, v_fl ? (8'b1 << c_fl) : 8'h00);
    chk("onehot_rr", o_rr, v_rr ? (8'b1 << c_rr) : 8'h00);
    chk("valid_align", {v_fh, v_fl}, {v_rr, v_rr});
    if (v_rr && gnt_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_grant", {29'd0, c_rr}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("code_fh", c_fh, e.fh);
        chk("code_fl", c_fl, e.fl);
        chk("code_rr", c_rr, e.rr);
        chk("onehot_exp_rr", o_rr, 8'b1 << e.rr);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req       = 8'h00;
    gnt_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_valid", {v_fh, v_fl, v_rr}, 3'b000);
    chk("rst_code", {c_fh, c_fl, c_rr}, 9'd0);
    chk("rst_onehot", {o_fh, o_fl, o_rr}, 24'd0);
    rst = 1'b0;
    cyc();

    // Fixed-priority pick from 0010_0100; one-cycle latency.
    req = 8'b0010_0100; gnt_ready = 1'b1;
    push(3'd5, 3'd2, 3'd5);
    chk("lat_pre_valid", v_rr, 1'b0);
    cyc();
    chk("lat_valid", v_rr, 1'b1);
    chk("lat_onehot_fh", o_fh, 8'b0010_0000);
    chk("lat_onehot_fl", o_fl, 8'b0000_0100);
    req = 8'h00;
    cyc();
    chk("b_idle", v_rr, 1'b0);

    // Backpressure: grant 5 held for 3 cycles while req moves to bit 0.
    req = 8'b0010_0000; gnt_ready = 1'b0;
    push(3'd5, 3'd5, 3'd5);
    cyc();
    req = 8'b0000_0001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_valid", v_rr, 1'b1);
      chk("bp_hold", {c_fh, c_fl, c_rr}, {3'd5, 3'd5, 3'd5});
    end
    gnt_ready = 1'b1;
    push(3'd0, 3'd0, 3'd0);
    cyc();
    chk("bp_next", c_rr, 3'd0);
    req = 8'h00;
    cyc();
    chk("bp_idle", v_rr, 1'b0);

    // Round-robin alternation between bits 7 and 0, no bubble.
    req = 8'b1000_0001;
    push(3'd7, 3'd0, 3'd7);
    push(3'd7, 3'd0, 3'd0);
    push(3'd7, 3'd0, 3'd7);
    push(3'd7, 3'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr2_no_bubble", v_rr, 1'b1);
    end
    req = 8'h00;
    cyc();

    // Round-robin over 7,4,1.
    req = 8'b1001_0010;
    push(3'd7, 3'd1, 3'd7);
    push(3'd7, 3'd1, 3'd4);
    push(3'd7, 3'd1, 3'd1);
    push(3'd7, 3'd1, 3'd7);
    push(3'd7, 3'd1, 3'd4);
    repeat (5) cyc();
    req = 8'h00;
    cyc();
    chk("rr3_idle", v_rr, 1'b0);

    // Single-cycle pulse captured and held, then transferred exactly once.
    req = 8'b0000_1000; gnt_ready = 1'b0;
    push(3'd3, 3'd3, 3'd3);
    cyc();
    req = 8'h00;
    chk("pulse_cap", {v_rr, c_rr}, {1'b1, 3'd3});
    repeat (2) cyc();
    chk("pulse_hold", {v_rr, c_rr}, {1'b1, 3'd3});
    gnt_ready = 1'b1;
    cyc();
    chk("pulse_done", v_rr, 1'b0);
    chk("pulse_code_kept", c_rr, 3'd3);
    repeat (2) cyc();
    chk("pulse_stay_idle", v_rr, 1'b0);

    // Async reset mid-grant, outputs clear without a clock edge.
    req = 8'b0010_0000; gnt_ready = 1'b0;
    cyc();
    req = 8'h00;
    chk("ar_pre", {v_rr, c_rr}, {1'b1, 3'd5});
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {v_fh, v_fl, v_rr}, 3'b000);
    chk("ar_code", {c_fh, c_fl, c_rr}, 9'd0);
    chk("ar_onehot", {o_fh, o_fl, o_rr}, 24'd0);
    cyc();
    rst = 1'b0;
    req = 8'b0000_0001; gnt_ready = 1'b1;
    push(3'd0, 3'd0, 3'd0);
    cyc();
    chk("ar_regrant", {v_rr, c_rr}, {1'b1, 3'd0});
    req = 8'h00;
    repeat (2) cyc();

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
